// File: rtl/edge_pkg.sv
// edge_pkg: edge-mode encoding and default parameters shared by the multi-channel edge detector.
package edge_pkg;
   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_FILTER_CYCLES = 3;
endpackage

// File: rtl/edge_channel.sv
// edge_channel: one channel of synchroniser, glitch filter, edge pulses, sticky flag and optional interval counter.
module edge_channel
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
   parameter int INTERVAL_WIDTH = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      din,
   input  logic [1:0]                mode,
   input  logic                      clear,
   output logic                      filtered,
   output logic                      pos_edge,
   output logic                      neg_edge,
   output logic                      event_pulse,
   output logic                      sticky,
   output logic [INTERVAL_WIDTH-1:0] interval,
   output logic                      interval_valid
);
   localparam int CW = FILTER_CYCLES > 0 ? $clog2(FILTER_CYCLES + 1) : 1;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   sync, differ, load;
   assign sync        = sync_q[SYNC_STAGES-1];
   assign differ      = sync ^ filtered;
   // load on the edge after sync has differed for FILTER_CYCLES consecutive edges
   assign load        = differ && cnt == CW'(FILTER_CYCLES);
   assign event_pulse = (pos_edge & mode[0]) | (neg_edge & mode[1]);
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= '0;
         filtered <= 1'b0;
         cnt      <= '0;
         pos_edge <= 1'b0;
         neg_edge <= 1'b0;
         sticky   <= 1'b0;
      end else begin
         sync_q[0] <= din;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         filtered <= load ? sync : filtered;
         cnt      <= (differ && !load) ? cnt + 1'b1 : '0;
         pos_edge <= load & sync;
         neg_edge <= load & ~sync;
         sticky   <= event_pulse | (sticky & ~clear);
      end
   end
`ifdef MULTI_EDGE_INTERVAL_EN
   localparam logic [INTERVAL_WIDTH-1:0] SAT = '1;
   logic [INTERVAL_WIDTH-1:0] icnt, inc;
   assign inc = icnt == SAT ? SAT : icnt + 1'b1;
   always_ff @(posedge clock) begin
      if (reset) begin
         icnt           <= SAT;
         interval       <= '0;
         interval_valid <= 1'b0;
      end else begin
         interval_valid <= event_pulse;
         interval       <= event_pulse ? inc : interval;
         icnt           <= event_pulse ? '0 : inc;
      end
   end
`else
   assign interval       = '0;
   assign interval_valid = 1'b0;
`endif
endmodule

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: CHANNELS independent edge detectors with packed buses.
// Interval measurement is built only when MULTI_EDGE_INTERVAL_EN is defined; otherwise interval ports read 0.
module multi_edge_detect
   import edge_pkg::*;
#(
   parameter int CHANNELS       = 4,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
   parameter int INTERVAL_WIDTH = 16
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [CHANNELS-1:0]                digital_in,
   input  logic [2*CHANNELS-1:0]              edge_mode,
   input  logic [CHANNELS-1:0]                event_clear,
   output logic [CHANNELS-1:0]                filtered_out,
   output logic [CHANNELS-1:0]                pos_edge,
   output logic [CHANNELS-1:0]                neg_edge,
   output logic [CHANNELS-1:0]                event_pulse,
   output logic [CHANNELS-1:0]                event_sticky,
   output logic [CHANNELS*INTERVAL_WIDTH-1:0] interval,
   output logic [CHANNELS-1:0]                interval_valid
);
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES),
         .INTERVAL_WIDTH(INTERVAL_WIDTH)
      ) u_ch (
         .clock         (clock),
         .reset         (reset),
         .din           (digital_in[i]),
         .mode          (edge_mode[2*i +: 2]),
         .clear         (event_clear[i]),
         .filtered      (filtered_out[i]),
         .pos_edge      (pos_edge[i]),
         .neg_edge      (neg_edge[i]),
         .event_pulse   (event_pulse[i]),
         .sticky        (event_sticky[i]),
         .interval      (interval[i*INTERVAL_WIDTH +: INTERVAL_WIDTH]),
         .interval_valid(interval_valid[i])
      );
   end
endmodule

// File: tb/tb_multi_edge_detect.sv
// tb_multi_edge_detect: directed checks of filtering, edge qualification, sticky flags, intervals and reset.
module tb_multi_edge_detect;
   import edge_pkg::*;
`ifdef MULTI_EDGE_INTERVAL_EN
   localparam bit IEN = 1'b1;
`else
   localparam bit IEN = 1'b0;
`endif
   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  digital_in, event_clear;
   logic [7:0]  edge_mode;
   logic [3:0]  filtered_out, pos_edge, neg_edge, event_pulse, event_sticky, interval_valid;
   logic [63:0] interval;
   int          errors = 0;
   int          checks = 0;
   int          pc, nc, ec, er;
   int          pcs[4];

   multi_edge_detect dut (
      .clock(clock), .reset(reset), .digital_in(digital_in), .edge_mode(edge_mode),
      .event_clear(event_clear), .filtered_out(filtered_out), .pos_edge(pos_edge),
      .neg_edge(neg_edge), .event_pulse(event_pulse), .event_sticky(event_sticky),
      .interval(interval), .interval_valid(interval_valid)
   );

   always #5 clock = ~clock;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      digital_in  = '0;
      event_clear = '0;
      edge_mode   = {EDGE_BOTH, EDGE_FALL, EDGE_BOTH, EDGE_RISE};
      step(2);
      chk("rst_filtered", filtered_out, 0);
      chk("rst_edges", {pos_edge, neg_edge, event_pulse}, 0);
      chk("rst_sticky", event_sticky, 0);
      chk("rst_interval", {interval_valid, interval}, 0);
      reset = 1'b0;

      // ch0 rising edge: latency SYNC_STAGES+FILTER_CYCLES from first capturing edge
      digital_in[0] = 1'b1;
      step(5);
      chk("ch0_pos_early", pos_edge, 0);
      chk("ch0_filt_early", filtered_out, 0);
      step(1);
      chk("ch0_pos", pos_edge, 4'b0001);
      chk("ch0_neg", neg_edge, 0);
      chk("ch0_event", event_pulse, 4'b0001);
      chk("ch0_filt", filtered_out, 4'b0001);
      chk("ch0_sticky_early", event_sticky, 0);
      step(1);
      chk("ch0_pos_end", pos_edge, 0);
      chk("ch0_event_end", event_pulse, 0);
      chk("ch0_sticky", event_sticky, 4'b0001);
      chk("ch0_ivalid", interval_valid, {3'b000, IEN});
      chk("ch0_interval", interval[15:0], IEN ? 16'hFFFF : 16'h0);

      // ch1 3-cycle glitch is rejected
      digital_in[1] = 1'b1;
      step(3);
      digital_in[1] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("ch1_glitch", {filtered_out[1], pos_edge[1], neg_edge[1]}, 0);
      end
      // ch1 4-cycle pulse is accepted
      pc = 0; nc = 0; ec = 0;
      digital_in[1] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 4) digital_in[1] = 1'b0;
         step(1);
         pc += int'(pos_edge[1]);
         nc += int'(neg_edge[1]);
         ec += int'(event_pulse[1]);
      end
      chk("ch1_pos_count", pc, 1);
      chk("ch1_neg_count", nc, 1);
      chk("ch1_event_count", ec, 2);
      chk("ch1_filt_final", filtered_out[1], 0);

      // ch2 falling-only mode
      pc = 0; nc = 0; ec = 0; er = 0;
      digital_in[2] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) digital_in[2] = 1'b0;
         step(1);
         pc += int'(pos_edge[2]);
         nc += int'(neg_edge[2]);
         ec += int'(event_pulse[2]);
         er += int'(event_pulse[2] & pos_edge[2]);
      end
      chk("ch2_pos_count", pc, 1);
      chk("ch2_neg_count", nc, 1);
      chk("ch2_event_count", ec, 1);
      chk("ch2_event_on_rise", er, 0);
      // ch2 mode off: level still tracks, no events
      edge_mode[5:4] = EDGE_OFF;
      pc = 0; ec = 0;
      digital_in[2] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(1);
         pc += int'(pos_edge[2]);
         ec += int'(event_pulse[2]);
      end
      chk("ch2_off_pos", pc, 1);
      chk("ch2_off_event", ec, 0);
      chk("ch2_off_filt", filtered_out[2], 1);

      // sticky: set wins over simultaneous clear, then clear alone
      event_clear = 4'hF;
      step(1);
      event_clear = 4'h0;
      chk("sticky_cleared", event_sticky, 0);
      digital_in[3] = 1'b1;
      step(6);
      chk("ch3_event", event_pulse, 4'b1000);
      event_clear[3] = 1'b1;
      step(1);
      chk("ch3_set_wins", event_sticky[3], 1);
      chk("ch3_ivalid_first", interval_valid, {IEN, 3'b000});
      chk("ch3_interval_first", interval[63:48], IEN ? 16'hFFFF : 16'h0);
      step(1);
      chk("ch3_clear", event_sticky[3], 0);
      event_clear = 4'h0;

      // falling event 100 cycles after the rising one
      step(92);
      digital_in[3] = 1'b0;
      step(6);
      chk("ch3_fall_event", {event_pulse[3], neg_edge[3]}, 2'b11);
      step(1);
      chk("ch3_ivalid_100", interval_valid, {IEN, 3'b000});
      chk("ch3_interval_100", interval[63:48], IEN ? 16'd100 : 16'h0);
      step(1);
      chk("ch3_ivalid_pulse", interval_valid, 0);
      // gap beyond 2^16-1 saturates
      step(70000);
      digital_in[3] = 1'b1;
      step(7);
      chk("ch3_ivalid_sat", interval_valid, {IEN, 3'b000});
      chk("ch3_interval_sat", interval[63:48], IEN ? 16'hFFFF : 16'h0);

      // reset during a filter count, then one pos_edge per high channel
      digital_in[1] = 1'b1;
      step(3);
      chk("mid_filt_pending", filtered_out, 4'b1101);
      reset = 1'b1;
      step(1);
      chk("mid_rst_filtered", filtered_out, 0);
      chk("mid_rst_edges", {pos_edge, neg_edge, event_pulse}, 0);
      chk("mid_rst_sticky", event_sticky, 0);
      chk("mid_rst_interval", {interval_valid, interval}, 0);
      reset = 1'b0;
      pcs = '{0, 0, 0, 0};
      for (int k = 0; k < 12; k++) begin
         step(1);
         for (int c = 0; c < 4; c++) pcs[c] += int'(pos_edge[c]);
      end
      for (int c = 0; c < 4; c++) chk($sformatf("post_rst_pos%0d", c), pcs[c], 1);
      chk("post_rst_filt", filtered_out, 4'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
